// File: rtl/l2_mem_pkg.sv
// rtl/l2_mem_pkg.sv - line/address widths, FSM encoding and default latencies for the L2 memory side
package l2_mem_pkg;

   localparam int LINE_W = 128;
   localparam int ADDR_W = 28;
   localparam int CNT_W  = 8;

   localparam int DEF_IDX_W      = 6;
   localparam int DEF_READ_LAT   = 8;
   localparam int DEF_WRITE_LAT  = 8;
   localparam int DEF_READY_HOLD = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

endpackage

// File: rtl/l2_mem_responder_if.sv
// rtl/l2_mem_responder_if.sv - L2-to-memory line request/response bundle
interface l2_mem_responder_if;
   import l2_mem_pkg::*;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              proto_err;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready, proto_err
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready, proto_err
   );

endinterface

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - DEPTH x LINE_W line store, synchronous write, registered read, synchronous clear
module mem_line_array
   import l2_mem_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [LINE_W-1:0] wdata_i,
   output logic [LINE_W-1:0] rdata_o
);

   localparam int DEPTH = 1 << IDX_W;

   logic [LINE_W-1:0] lines_q [DEPTH];
   logic [LINE_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            lines_q[i] <= '0;
         end
         rdata_q <= '0;
      end else begin
         if (we_i) begin
            lines_q[idx_i] <= wdata_i;
         end
         if (re_i) begin
            rdata_q <= lines_q[idx_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_mem_responder.sv
// rtl/l2_mem_responder.sv - single-outstanding memory responder with programmable read/write latency
module l2_mem_responder
   import l2_mem_pkg::*;
#(
   parameter int IDX_W      = DEF_IDX_W,
   parameter int READ_LAT   = DEF_READ_LAT,
   parameter int WRITE_LAT  = DEF_WRITE_LAT,
   parameter int READY_HOLD = DEF_READY_HOLD
) (
   input  logic               clk,
   input  logic               reset,
   l2_mem_responder_if.slave  mem_if
);

   if (READ_LAT < 1 || READ_LAT > 255) begin : g_bad_read_lat
      $error("READ_LAT must be in 1..255");
   end
   if (WRITE_LAT < 1 || WRITE_LAT > 255) begin : g_bad_write_lat
      $error("WRITE_LAT must be in 1..255");
   end
   if (READY_HOLD < 1 || READY_HOLD > 256) begin : g_bad_ready_hold
      $error("READY_HOLD must be in 1..256");
   end

   localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WRITE_LAT - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(READY_HOLD - 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  hold_q, hold_d;
   logic              ready_q, ready_d;
   logic              proto_err_q, proto_err_d;
   logic              arr_we, arr_re;

   // Upper address bits alias onto the same line by design.
   logic unused_addr_hi;
   assign unused_addr_hi = ^mem_if.mem_addr[ADDR_W-1:IDX_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_READ;
         idx_q       <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         hold_q      <= '0;
         ready_q     <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         ready_q     <= ready_d;
         proto_err_q <= proto_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      ready_d     = ready_q;
      proto_err_d = 1'b0;
      arr_we      = 1'b0;
      arr_re      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_if.mem_read || mem_if.mem_write) begin
               // A simultaneous read+write is serviced as the write.
               op_d        = mem_if.mem_write ? OP_WRITE : OP_READ;
               idx_d       = mem_if.mem_addr[IDX_W-1:0];
               wdata_d     = mem_if.mem_wdata;
               cnt_d       = mem_if.mem_write ? WR_LOAD : RD_LOAD;
               proto_err_d = mem_if.mem_read && mem_if.mem_write;
               state_d     = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               arr_we  = (op_q == OP_WRITE);
               arr_re  = (op_q == OP_READ);
               ready_d = 1'b1;
               hold_d  = HOLD_LOAD;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            if (hold_q == '0) begin
               ready_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   mem_line_array #(
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (mem_if.mem_rdata)
   );

   assign mem_if.mem_ready = ready_q;
   assign mem_if.proto_err = proto_err_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb/tb_l2_mem_responder.sv - randomized scoreboard bench for l2_mem_responder
module tb_l2_mem_responder;
   import l2_mem_pkg::*;

   localparam int IDX_W  = 6;
   localparam int RD_LAT = 8;
   localparam int WR_LAT = 8;
   localparam int HOLD   = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   l2_mem_responder_if bus();

   l2_mem_responder #(
      .IDX_W      (IDX_W),
      .READ_LAT   (RD_LAT),
      .WRITE_LAT  (WR_LAT),
      .READY_HOLD (HOLD)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .mem_if (bus)
   );

   int cyc = 0;
   bit rst_at_edge = 1'b1;
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= reset;
   end

   logic [127:0] model [64];
   bit           ready_at [int];
   bit           proto_at [int];
   logic [127:0] rdata_chg [int];
   logic [127:0] cur_rdata = '0;
   int           free_cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Outputs sampled mid-cycle against expected response windows.
   always @(negedge clk) begin
      if (rst_at_edge) begin
         cur_rdata = '0;
         chk("reset_ready", 128'(bus.mem_ready), 128'(0));
         chk("reset_proto", 128'(bus.proto_err), 128'(0));
         chk("reset_rdata", bus.mem_rdata, 128'(0));
      end else begin
         if (rdata_chg.exists(cyc)) cur_rdata = rdata_chg[cyc];
         chk("mem_ready", 128'(bus.mem_ready), 128'(ready_at.exists(cyc)));
         chk("proto_err", 128'(bus.proto_err), 128'(proto_at.exists(cyc)));
         chk("mem_rdata", bus.mem_rdata, cur_rdata);
      end
   end

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) model[i] = '0;
      free_cyc = 0;
   endtask

   // Called on a negedge; returns on the negedge of the first mem_ready cycle.
   task automatic txn(input bit wr, input bit rd, input logic [27:0] addr,
                      input logic [127:0] data, input bit chain);
      int acc, rise, idx;
      bus.mem_write = wr;
      bus.mem_read  = rd;
      bus.mem_addr  = addr;
      bus.mem_wdata = data;
      acc  = (cyc + 1 > free_cyc) ? cyc + 1 : free_cyc;
      rise = acc + (wr ? WR_LAT : RD_LAT);
      idx  = int'(addr[IDX_W-1:0]);
      if (wr) model[idx] = data;
      else    rdata_chg[rise] = model[idx];
      for (int k = 0; k < HOLD; k++) ready_at[rise + k] = 1'b1;
      if (wr && rd) proto_at[acc] = 1'b1;
      free_cyc = rise + HOLD + 1;
      while (cyc < rise) begin
         @(negedge clk);
         if (cyc >= acc && cyc < rise) begin
            bus.mem_addr  = 28'($urandom);
            bus.mem_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      if (!chain) begin
         bus.mem_read  = 1'b0;
         bus.mem_write = 1'b0;
      end
   endtask

   initial begin
      logic [27:0] a;
      int kind;
      bit ch;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      @(negedge clk);
      do_reset(3);

      txn(1'b0, 1'b1, 28'h0000005, 128'h0, 1'b0);
      repeat (2) @(negedge clk);
      txn(1'b1, 1'b0, 28'h0000005, 128'hDEADBEEF_00112233_44556677_89AB0123, 1'b0);
      repeat (3) @(negedge clk);
      txn(1'b0, 1'b1, 28'h0000005, 128'h0, 1'b0);
      repeat (3) @(negedge clk);
      txn(1'b1, 1'b0, 28'h0000045, 128'h11112222_33334444_55556666_77778888, 1'b0);
      repeat (1) @(negedge clk);
      txn(1'b0, 1'b1, 28'h0000005, 128'h0, 1'b0);
      repeat (2) @(negedge clk);
      txn(1'b1, 1'b0, 28'h0000009, 128'hCAFEF00D_0BADC0DE_FEEDFACE_12345678, 1'b1);
      txn(1'b0, 1'b1, 28'h0000009, 128'h0, 1'b0);
      repeat (2) @(negedge clk);
      txn(1'b1, 1'b1, 28'h000000A, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1'b0);
      txn(1'b0, 1'b1, 28'h000000A, 128'h0, 1'b0);
      repeat (2) @(negedge clk);

      // Write aborted by reset three cycles after acceptance.
      bus.mem_write = 1'b1;
      bus.mem_read  = 1'b0;
      bus.mem_addr  = 28'h0000005;
      bus.mem_wdata = 128'h99999999_88888888_77777777_66666666;
      repeat (3) @(negedge clk);
      do_reset(2);
      txn(1'b0, 1'b1, 28'h0000005, 128'h0, 1'b0);
      repeat (2) @(negedge clk);

      for (int t = 0; t < 60; t++) begin
         a      = 28'($urandom);
         a[5:3] = 3'($urandom_range(0, 7));
         a[2:0] = 3'($urandom_range(0, 3));
         kind   = $urandom_range(0, 9);
         ch     = (t != 59) && ($urandom_range(0, 1) == 1);
         txn(kind >= 4, (kind < 4) || (kind == 9), a,
             {$urandom, $urandom, $urandom, $urandom}, ch);
         if (!ch) repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (HOLD + 4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
